// File: rtl/product_accumulator_pkg.sv
// Shared constants, FSM state encoding and full-adder cell helpers for the
// product accumulator.
package product_accumulator_pkg;

   localparam int ACC_W    = 12;
   localparam int PROD_MAX = 225;

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_DONE  = 1'b1;

   // Full-adder cell: sum output.
   function automatic logic fa_sum(input logic a, input logic b, input logic ci);
      return a ^ b ^ ci;
   endfunction

   // Full-adder cell: carry output (majority of the three inputs).
   function automatic logic fa_carry(input logic a, input logic b, input logic ci);
      return (a & b) | (a & ci) | (b & ci);
   endfunction

endpackage

// File: rtl/acc_adder_12bit.sv
// 12-bit ripple-carry adder built from full-adder cells. The final carry is
// dropped: the largest possible frame sum (16 * 225 = 3600) fits in 12 bits.
module acc_adder_12bit
   import product_accumulator_pkg::*;
(
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum
);

   // Ripple the carry from bit 0 upward through one full-adder cell per bit.
   always_comb begin
      logic carry_s;
      carry_s = 1'b0;
      sum     = {ACC_W{1'b0}};
      for (int i = 0; i < ACC_W; i++) begin
         sum[i]  = fa_sum(a[i], b[i], carry_s);
         carry_s = fa_carry(a[i], b[i], carry_s);
      end
   end

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT unsigned 8-bit products per frame, presents the frame sum with a
// valid/ready handshake and counts frames taken by the consumer.
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int COUNT = 4,
   parameter int ACC_W = product_accumulator_pkg::ACC_W
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [7:0]       in_prod,
   output logic             in_ready,
   output logic             out_valid,
   output logic [ACC_W-1:0] out_sum,
   input  logic             out_ready,
   output logic [3:0]       frame_cnt
);

   localparam logic [3:0] LAST_IDX = 4'(COUNT - 1);

   logic [0:0]       state_r;
   logic [3:0]       idx_r;
   logic [ACC_W-1:0] acc_r;
   logic [3:0]       frame_cnt_r;
   logic [ACC_W-1:0] prod_ext_s;
   logic [ACC_W-1:0] add_s;
   logic             take_s;
   logic             last_s;
   logic             consume_s;

   assign prod_ext_s = {{(ACC_W - 8){1'b0}}, in_prod};
   assign take_s     = in_valid && (state_r == ST_ACCUM);
   assign last_s     = take_s && (idx_r == LAST_IDX);
   assign consume_s  = (state_r == ST_DONE) && out_ready;

   acc_adder_12bit u_adder (
      .a   (acc_r),
      .b   (prod_ext_s),
      .sum (add_s)
   );

   // Two-state frame FSM: collect products in ACCUM, hold the result in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_ACCUM;
      end else if (clr) begin
         state_r <= ST_ACCUM;
      end else begin
         case (state_r)
            ST_ACCUM: begin
               if (last_s) begin
                  state_r <= ST_DONE;
               end else begin
                  state_r <= ST_ACCUM;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_r <= ST_ACCUM;
               end else begin
                  state_r <= ST_DONE;
               end
            end
            default: state_r <= ST_ACCUM;
         endcase
      end
   end

   // Product index and running sum; the first product of a frame loads directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r <= 4'd0;
         acc_r <= {ACC_W{1'b0}};
      end else if (clr) begin
         idx_r <= 4'd0;
         acc_r <= {ACC_W{1'b0}};
      end else if (take_s) begin
         if (idx_r == 4'd0) begin
            acc_r <= prod_ext_s;
         end else begin
            acc_r <= add_s;
         end
         if (last_s) begin
            idx_r <= 4'd0;
         end else begin
            idx_r <= idx_r + 4'd1;
         end
      end else begin
         idx_r <= idx_r;
         acc_r <= acc_r;
      end
   end

   // Count frames handed to the consumer; an abort leaves the count alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_r <= 4'd0;
      end else if (clr) begin
         frame_cnt_r <= frame_cnt_r;
      end else if (consume_s) begin
         frame_cnt_r <= frame_cnt_r + 4'd1;
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end

   // All outputs come straight from flops.
   assign in_ready  = (state_r == ST_ACCUM);
   assign out_valid = (state_r == ST_DONE);
   assign out_sum   = acc_r;
   assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: three instances (COUNT = 4, 16
// and 1) share the same stimulus; each sequence checks the relevant instance.
module tb_product_accumulator;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        in_valid;
   logic [7:0]  in_prod;
   logic        out_ready;

   logic        in_ready4,  out_valid4;
   logic [11:0] out_sum4;
   logic [3:0]  frame_cnt4;
   logic        in_ready16, out_valid16;
   logic [11:0] out_sum16;
   logic [3:0]  frame_cnt16;
   logic        in_ready1,  out_valid1;
   logic [11:0] out_sum1;
   logic [3:0]  frame_cnt1;

   int n_cmp;
   int n_bad;

   product_accumulator #(.COUNT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_prod(in_prod),
      .in_ready(in_ready4), .out_valid(out_valid4), .out_sum(out_sum4),
      .out_ready(out_ready), .frame_cnt(frame_cnt4)
   );

   product_accumulator #(.COUNT(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_prod(in_prod),
      .in_ready(in_ready16), .out_valid(out_valid16), .out_sum(out_sum16),
      .out_ready(out_ready), .frame_cnt(frame_cnt16)
   );

   product_accumulator #(.COUNT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_prod(in_prod),
      .in_ready(in_ready1), .out_valid(out_valid1), .out_sum(out_sum1),
      .out_ready(out_ready), .frame_cnt(frame_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [7:0]  prod;
      logic        ordy;
      logic        clr;
      logic        exp_in_ready;
      logic        exp_out_valid;
      logic [11:0] exp_sum;
      logic [3:0]  exp_fcnt;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check4(input string name, input logic rdy, input logic ov,
                         input int sum, input int fc);
      check({name, ".in_ready"},  int'(in_ready4),  int'(rdy));
      check({name, ".out_valid"}, int'(out_valid4), int'(ov));
      check({name, ".out_sum"},   int'(out_sum4),   sum);
      check({name, ".frame_cnt"}, int'(frame_cnt4), fc);
   endtask

   // Drive one cycle's inputs, clock, then sample 1 time unit after the edge.
   task automatic step(input logic v, input logic [7:0] p, input logic ordy, input logic c);
      in_valid  = v;
      in_prod   = p;
      out_ready = ordy;
      clr       = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; in_prod = 8'd0; out_ready = 1'b0; clr = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic v, input int p, input logic ordy, input logic c,
                               input logic rdy, input logic ov, input int sum, input int fc);
      vec_t r;
      r.valid = v; r.prod = 8'(p); r.ordy = ordy; r.clr = c;
      r.exp_in_ready = rdy; r.exp_out_valid = ov; r.exp_sum = 12'(sum); r.exp_fcnt = 4'(fc);
      return r;
   endfunction

   initial begin
      int pulses;
      n_cmp = 0;
      n_bad = 0;

      // Table for the COUNT=4 instance: {valid, prod, out_ready, clr, ready, ovalid, sum, fcnt}
      // Basic frame 15+30+45+60, consumed immediately.
      vecs.push_back(mk(1'b1, 15, 1'b1, 1'b0, 1'b1, 1'b0,  15, 0));
      vecs.push_back(mk(1'b1, 30, 1'b1, 1'b0, 1'b1, 1'b0,  45, 0));
      vecs.push_back(mk(1'b1, 45, 1'b1, 1'b0, 1'b1, 1'b0,  90, 0));
      vecs.push_back(mk(1'b1, 60, 1'b1, 1'b0, 1'b0, 1'b1, 150, 0));
      vecs.push_back(mk(1'b0,  0, 1'b1, 1'b0, 1'b1, 1'b0, 150, 1));
      // Frame 1+2+3+4 with back-pressure for 5 cycles while upstream offers 200.
      vecs.push_back(mk(1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0,   1, 1));
      vecs.push_back(mk(1'b1,  2, 1'b0, 1'b0, 1'b1, 1'b0,   3, 1));
      vecs.push_back(mk(1'b1,  3, 1'b0, 1'b0, 1'b1, 1'b0,   6, 1));
      vecs.push_back(mk(1'b1,  4, 1'b0, 1'b0, 1'b0, 1'b1,  10, 1));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(1'b1, 200, 1'b0, 1'b0, 1'b0, 1'b1, 10, 1));
      vecs.push_back(mk(1'b0,  0, 1'b1, 1'b0, 1'b1, 1'b0,  10, 2));
      // 10, 20, then abort together with product 99, then 1..4.
      vecs.push_back(mk(1'b1, 10, 1'b0, 1'b0, 1'b1, 1'b0,  10, 2));
      vecs.push_back(mk(1'b1, 20, 1'b0, 1'b0, 1'b1, 1'b0,  30, 2));
      vecs.push_back(mk(1'b1, 99, 1'b0, 1'b1, 1'b1, 1'b0,   0, 2));
      vecs.push_back(mk(1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0,   1, 2));
      vecs.push_back(mk(1'b1,  2, 1'b0, 1'b0, 1'b1, 1'b0,   3, 2));
      vecs.push_back(mk(1'b1,  3, 1'b0, 1'b0, 1'b1, 1'b0,   6, 2));
      vecs.push_back(mk(1'b1,  4, 1'b0, 1'b0, 1'b0, 1'b1,  10, 2));
      vecs.push_back(mk(1'b0,  0, 1'b1, 1'b0, 1'b1, 1'b0,  10, 3));
      // Frame 5*4, then abort in DONE while the consumer is ready: result dropped.
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1'b1, 5, 1'b0, 1'b0, 1'b1, 1'b0, 5 * (i + 1), 3));
      vecs.push_back(mk(1'b1,  5, 1'b0, 1'b0, 1'b0, 1'b1,  20, 3));
      vecs.push_back(mk(1'b0,  0, 1'b1, 1'b1, 1'b1, 1'b0,   0, 3));
      vecs.push_back(mk(1'b0,  0, 1'b1, 1'b0, 1'b1, 1'b0,   0, 3));

      rst_n = 1'b0;
      in_valid = 1'b0; in_prod = 8'd0; out_ready = 1'b0; clr = 1'b0;
      #2;
      check4("reset", 1'b1, 1'b0, 0, 0);
      do_reset();
      check4("after_reset", 1'b1, 1'b0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].valid, vecs[i].prod, vecs[i].ordy, vecs[i].clr);
         check4($sformatf("vec%0d", i), vecs[i].exp_in_ready, vecs[i].exp_out_valid,
                int'(vecs[i].exp_sum), int'(vecs[i].exp_fcnt));
      end

      // COUNT=16: sixteen maximum products give 3600 without wrap.
      do_reset();
      for (int i = 0; i < 15; i++) step(1'b1, 8'd225, 1'b1, 1'b0);
      check("max16.partial_valid", int'(out_valid16), 0);
      check("max16.partial_sum",   int'(out_sum16),   3375);
      step(1'b1, 8'd225, 1'b1, 1'b0);
      check("max16.out_valid", int'(out_valid16), 1);
      check("max16.out_sum",   int'(out_sum16),   3600);
      check("max16.in_ready",  int'(in_ready16),  0);
      step(1'b0, 8'd0, 1'b1, 1'b0);
      check("max16.frame_cnt", int'(frame_cnt16), 1);
      check("max16.in_ready_back", int'(in_ready16), 1);

      // Asynchronous reset mid-frame after one completed frame.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 8'd9, 1'b0, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0);
      check4("prearst", 1'b1, 1'b0, 36, 1);
      for (int i = 0; i < 3; i++) step(1'b1, 8'd9, 1'b0, 1'b0);
      check("prearst.partial", int'(out_sum4), 27);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check4("arst_immediate", 1'b1, 1'b0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) step(1'b1, 8'd5, 1'b0, 1'b0);
      check4("post_arst", 1'b0, 1'b1, 20, 0);

      // COUNT=1: 17 frames of 7 with continuous valid/ready; COUNT=4 throughput
      // observed on the same stimulus (4 products per 5 cycles).
      do_reset();
      pulses = 0;
      for (int f = 0; f < 17; f++) begin
         step(1'b1, 8'd7, 1'b1, 1'b0);
         check($sformatf("cnt1.f%0d.out_valid", f), int'(out_valid1), 1);
         check($sformatf("cnt1.f%0d.out_sum", f),   int'(out_sum1),   7);
         if (out_valid4) pulses++;
         step(1'b1, 8'd7, 1'b1, 1'b0);
         check($sformatf("cnt1.f%0d.out_valid_low", f), int'(out_valid1), 0);
         if (out_valid4) pulses++;
      end
      check("cnt1.frame_cnt_wrap", int'(frame_cnt1), 1);
      check("cnt4.throughput_pulses", pulses, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
